unpacker: RTL and testbench

- Width-down converter: accepts one packed word of packed_num_p chunks, each unpacked_width_p bits wide.
- Emits the chunks one per cycle, least-significant chunk first.
- Exact inverse of the packing stage: chunk k is taken from bits [k*unpacked_width_p +: unpacked_width_p].
- Sits directly downstream of the packer, or of any link that carries packed pixel words, and restores the per-pixel stream for the consumers that follow.

---
 rtl/unpacker.sv | 80 ++++++++
 tb/tb_unpacker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/unpacker.sv
// Width-down converter: splits one packed word into packed_num_p chunks and
// emits them one per cycle, least-significant chunk first.
module unpacker #(
  parameter int unpacked_width_p = 2,
  parameter int packed_num_p     = 4,
  localparam int packed_width_p  = unpacked_width_p * packed_num_p
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic [packed_width_p-1:0]   packed_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [unpacked_width_p-1:0] unpacked_o,
  output logic                        last_o,
  output logic                        valid_o,
  input  logic                        ready_i
);

  localparam int count_width_lp = $clog2(packed_num_p);
  localparam logic [count_width_lp-1:0] last_idx_lp = count_width_lp'(packed_num_p - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                    state_q, state_d;
  logic [packed_width_p-1:0] data_q, data_d;
  logic [count_width_lp-1:0] count_q, count_d;
  logic                      in_fire, out_fire;

  assign valid_o    = (state_q == FULL);
  assign unpacked_o = data_q[unpacked_width_p-1:0];
  assign last_o     = valid_o & (count_q == last_idx_lp);
  // A new word may load in the cycle the final chunk leaves, so words stream without a bubble.
  assign ready_o    = ~valid_o | (last_o & ready_i);
  assign in_fire    = valid_i & ready_o;
  assign out_fire   = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = FULL;
          data_d  = packed_i;
          count_d = '0;
        end
      end
      FULL: begin
        if (out_fire) begin
          if (!last_o) begin
            data_d  = data_q >> unpacked_width_p;
            count_d = count_q + count_width_lp'(1);
          end else if (in_fire) begin
            data_d  = packed_i;
            count_d = '0;
          end else begin
            state_d = EMPTY;
            data_d  = '0;
            count_d = '0;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= EMPTY;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_unpacker.sv
// Bench for unpacker: per-cycle vector table with a chunk scoreboard, plus
// hand-written async-reset and narrow-configuration sequences.
module tb_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_ni;
  logic [7:0] packed_i;
  logic       valid_i, ready_o, last_o, valid_o, ready_i;
  logic [1:0] unpacked_o;

  logic [7:0] packed2_i;
  logic       valid2_i, ready2_o, last2_o, valid2_o, ready2_i;
  logic [3:0] unpacked2_o;

  unpacker #(.unpacked_width_p(2), .packed_num_p(4)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .packed_i(packed_i), .valid_i(valid_i),
    .ready_o(ready_o), .unpacked_o(unpacked_o), .last_o(last_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  unpacker #(.unpacked_width_p(4), .packed_num_p(2)) dut2 (
    .clk_i(clk), .reset_ni(reset_ni), .packed_i(packed2_i), .valid_i(valid2_i),
    .ready_o(ready2_o), .unpacked_o(unpacked2_o), .last_o(last2_o),
    .valid_o(valid2_o), .ready_i(ready2_i)
  );

  typedef struct {
    logic       vld;
    logic [7:0] pk;
    logic       rdy;
    logic       e_valid;
    logic [1:0] e_data;
    logic       e_last;
    logic       e_ready;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] sb[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then score any fires that
  // the coming rising edge will commit.
  task automatic cycle(input logic v, input logic [7:0] p, input logic r);
    @(negedge clk);
    valid_i = v; packed_i = p; ready_i = r;
    #1;
    if (valid_o && ready_i) begin
      if (sb.size() == 0) begin
        check("sb_spurious", {5'b0, last_o, unpacked_o}, 8'hFF);
      end else begin
        logic [2:0] e;
        e = sb.pop_front();
        check("sb_chunk", {5'b0, last_o, unpacked_o}, {5'b0, e});
      end
    end
    if (valid_i && ready_o) begin
      for (int k = 0; k < 4; k++) sb.push_back({(k == 3), p[2*k +: 2]});
    end
  endtask

  task automatic addv(input logic v, input logic [7:0] p, input logic r,
                      input logic ev, input logic [1:0] ed, input logic el, input logic er);
    vecs.push_back('{v, p, r, ev, ed, el, er});
  endtask

  initial begin
    reset_ni = 1'b0;
    packed_i = '0; valid_i = 1'b0; ready_i = 1'b1;
    packed2_i = '0; valid2_i = 1'b0; ready2_i = 1'b1;

    // Single word E4 -> 0,1,2,3
    addv(1, 8'hE4, 1, 0, 0, 0, 1);
    addv(0, 8'h00, 1, 1, 0, 0, 0);
    addv(0, 8'h00, 1, 1, 1, 0, 0);
    addv(0, 8'h00, 1, 1, 2, 0, 0);
    addv(0, 8'h00, 1, 1, 3, 1, 1);
    addv(0, 8'h00, 1, 0, 0, 0, 1);
    // Back-to-back E4 then 1B, no bubble
    addv(1, 8'hE4, 1, 0, 0, 0, 1);
    addv(1, 8'h1B, 1, 1, 0, 0, 0);
    addv(1, 8'h1B, 1, 1, 1, 0, 0);
    addv(1, 8'h1B, 1, 1, 2, 0, 0);
    addv(1, 8'h1B, 1, 1, 3, 1, 1);
    addv(0, 8'h00, 1, 1, 3, 0, 0);
    addv(0, 8'h00, 1, 1, 2, 0, 0);
    addv(0, 8'h00, 1, 1, 1, 0, 0);
    addv(0, 8'h00, 1, 1, 0, 1, 1);
    addv(0, 8'h00, 1, 0, 0, 0, 1);
    // Backpressure on chunk 1; valid_i mid-word must be ignored
    addv(1, 8'hE4, 1, 0, 0, 0, 1);
    addv(0, 8'h00, 1, 1, 0, 0, 0);
    addv(0, 8'h00, 0, 1, 1, 0, 0);
    addv(1, 8'hFF, 0, 1, 1, 0, 0);
    addv(0, 8'h00, 0, 1, 1, 0, 0);
    addv(0, 8'h00, 1, 1, 1, 0, 0);
    addv(0, 8'h00, 1, 1, 2, 0, 0);
    addv(0, 8'h00, 1, 1, 3, 1, 1);
    // Upstream stall, then 1B; stall on last chunk blocks the next word
    addv(0, 8'h00, 1, 0, 0, 0, 1);
    addv(0, 8'h00, 1, 0, 0, 0, 1);
    addv(1, 8'h1B, 1, 0, 0, 0, 1);
    addv(0, 8'h00, 1, 1, 3, 0, 0);
    addv(0, 8'h00, 1, 1, 2, 0, 0);
    addv(0, 8'h00, 1, 1, 1, 0, 0);
    addv(1, 8'hE4, 0, 1, 0, 1, 0);
    addv(1, 8'hE4, 1, 1, 0, 1, 1);
    addv(0, 8'h00, 1, 1, 0, 0, 0);
    addv(0, 8'h00, 1, 1, 1, 0, 0);
    addv(0, 8'h00, 1, 1, 2, 0, 0);
    addv(0, 8'h00, 1, 1, 3, 1, 1);
    addv(0, 8'h00, 1, 0, 0, 0, 1);

    #12;
    check("rst_valid", {7'b0, valid_o}, 8'h00);
    check("rst_last",  {7'b0, last_o},  8'h00);
    check("rst_data",  {6'b0, unpacked_o}, 8'h00);
    check("rst_ready", {7'b0, ready_o}, 8'h01);
    @(negedge clk);
    reset_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].vld, vecs[i].pk, vecs[i].rdy);
      check($sformatf("v%0d_valid", i), {7'b0, valid_o},    {7'b0, vecs[i].e_valid});
      check($sformatf("v%0d_data", i),  {6'b0, unpacked_o}, {6'b0, vecs[i].e_data});
      check($sformatf("v%0d_last", i),  {7'b0, last_o},     {7'b0, vecs[i].e_last});
      check($sformatf("v%0d_ready", i), {7'b0, ready_o},    {7'b0, vecs[i].e_ready});
    end
    check("sb_drained", 8'(sb.size()), 8'h00);

    // Async reset mid-word: chunk 1 on display, reset between edges
    cycle(1, 8'hE4, 1);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);
    check("pre_rst_data", {6'b0, unpacked_o}, 8'h01);
    #2;
    reset_ni = 1'b0;
    #1;
    check("arst_valid", {7'b0, valid_o}, 8'h00);
    check("arst_last",  {7'b0, last_o},  8'h00);
    check("arst_ready", {7'b0, ready_o}, 8'h01);
    check("arst_data",  {6'b0, unpacked_o}, 8'h00);
    sb.delete();
    @(negedge clk);
    reset_ni = 1'b1;
    cycle(1, 8'hFF, 1);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 8'h00, 1);
      check($sformatf("ff_chunk%0d", k), {5'b0, last_o, unpacked_o}, {5'b0, (k == 3), 2'd3});
    end
    cycle(0, 8'h00, 1);
    check("ff_idle_valid", {7'b0, valid_o}, 8'h00);
    check("ff_drained", 8'(sb.size()), 8'h00);

    // Narrow configuration: 4-bit chunks, 2 per word, A5 -> 5 then A
    @(negedge clk);
    valid2_i = 1'b1; packed2_i = 8'hA5; ready2_i = 1'b1;
    #1;
    check("n_ready0", {7'b0, ready2_o}, 8'h01);
    check("n_valid0", {7'b0, valid2_o}, 8'h00);
    @(negedge clk);
    valid2_i = 1'b0; packed2_i = 8'h00;
    #1;
    check("n_chunk0", {3'b0, valid2_o, unpacked2_o}, 8'h15);
    check("n_last0",  {7'b0, last2_o}, 8'h00);
    @(negedge clk);
    #1;
    check("n_chunk1", {3'b0, valid2_o, unpacked2_o}, 8'h1A);
    check("n_last1",  {7'b0, last2_o}, 8'h01);
    check("n_ready1", {7'b0, ready2_o}, 8'h01);
    @(negedge clk);
    #1;
    check("n_idle", {7'b0, valid2_o}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
